// File: rtl/sar_adc_scan.sv
// rtl/sar_adc_scan.sv - multi-channel SAR ADC scan sequencer; optional averaging via SAR_AVG_EN
module sar_adc_scan #(
  parameter int ADC_WIDTH  = 8,
  parameter int NUM_CH     = 4,
  parameter int SETTLE_CYC = 2,
  parameter int AVG_LOG2   = 2,
  localparam int CH_W      = $clog2(NUM_CH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 cont,
  input  logic [NUM_CH-1:0]    ch_mask,
  input  logic                 cmp,
  output logic [CH_W-1:0]      mux_sel,
  output logic                 sample,
  output logic [ADC_WIDTH-1:0] DACF,
  output logic                 busy,
  output logic                 eoc,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic [ADC_WIDTH-1:0] dout,
  output logic [CH_W-1:0]      dout_ch
);

  localparam int BW = (ADC_WIDTH > 1) ? $clog2(ADC_WIDTH) : 1;
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CONV, S_LOAD} state_t;

  state_t                state_q, state_d;
  logic [NUM_CH-1:0]     mask_q, mask_d;
  logic [CH_W-1:0]       mux_sel_q, mux_sel_d;
  logic [SW-1:0]         settle_q, settle_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [ADC_WIDTH-1:0]  acc_q, acc_d;
  logic                  busy_q, busy_d;
  logic                  eoc_q, eoc_d;
  logic                  dout_valid_q, dout_valid_d;
  logic [ADC_WIDTH-1:0]  dout_q, dout_d;
  logic [CH_W-1:0]       dout_ch_q, dout_ch_d;

`ifdef SAR_AVG_EN
  localparam int SUM_W = ADC_WIDTH + AVG_LOG2;
  logic [SUM_W-1:0]      sum_q, sum_d;
  logic [AVG_LOG2-1:0]   avg_q, avg_d;
`else
  // AVG_LOG2 only matters for the averaging build; this empty block keeps it referenced.
  if (AVG_LOG2 < 0) begin : g_avg_log2_unused
  end
`endif

  logic [CH_W-1:0]       first_ch, next_ch;
  logic                  first_found, next_found;
  logic [ADC_WIDTH-1:0]  bit_onehot, trial, conv_res;

  // Trial code sets the bit under test on top of the bits already decided.
  assign bit_onehot = ADC_WIDTH'(1) << bit_q;
  assign trial      = acc_q | bit_onehot;
  assign conv_res   = cmp ? trial : acc_q;

  // Channel picking: lowest requested channel for a new scan, next higher captured one mid-scan.
  always_comb begin
    first_ch    = '0;
    first_found = 1'b0;
    next_ch     = '0;
    next_found  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!first_found && ch_mask[i]) begin
        first_found = 1'b1;
        first_ch    = CH_W'(i);
      end
      if (!next_found && mask_q[i] && (i > int'(mux_sel_q))) begin
        next_found = 1'b1;
        next_ch    = CH_W'(i);
      end
    end
  end

  // Sequencer next-state and result register update.
  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    mux_sel_d    = mux_sel_q;
    settle_d     = settle_q;
    bit_d        = bit_q;
    acc_d        = acc_q;
    busy_d       = busy_q;
    eoc_d        = 1'b0;
    dout_d       = dout_q;
    dout_ch_d    = dout_ch_q;
    dout_valid_d = dout_valid_q & ~dout_ready;
`ifdef SAR_AVG_EN
    sum_d        = sum_q;
    avg_d        = avg_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start && !busy_q && first_found) begin
          mask_d    = ch_mask;
          mux_sel_d = first_ch;
          settle_d  = '0;
          acc_d     = '0;
          busy_d    = 1'b1;
          state_d   = S_SETTLE;
`ifdef SAR_AVG_EN
          sum_d     = '0;
          avg_d     = '0;
`endif
        end
      end
      S_SETTLE: begin
        acc_d = '0;
        if (settle_q == SW'(SETTLE_CYC - 1)) begin
          bit_d   = BW'(ADC_WIDTH - 1);
          state_d = S_CONV;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      S_CONV: begin
        acc_d = conv_res;
        if (bit_q == '0) begin
`ifdef SAR_AVG_EN
          // Back-to-back conversions on the same channel; no resettling between them.
          sum_d = sum_q + SUM_W'(conv_res);
          if (avg_q == '1) begin
            state_d = S_LOAD;
          end else begin
            avg_d = avg_q + 1'b1;
            acc_d = '0;
            bit_d = BW'(ADC_WIDTH - 1);
          end
`else
          state_d = S_LOAD;
`endif
        end else begin
          bit_d = bit_q - 1'b1;
        end
      end
      S_LOAD: begin
        // Load only into an empty or draining result register; otherwise hold here.
        if (!dout_valid_q || dout_ready) begin
          dout_valid_d = 1'b1;
          dout_ch_d    = mux_sel_q;
`ifdef SAR_AVG_EN
          dout_d       = sum_q[SUM_W-1:AVG_LOG2];
          sum_d        = '0;
          avg_d        = '0;
`else
          dout_d       = acc_q;
`endif
          acc_d        = '0;
          settle_d     = '0;
          if (next_found) begin
            mux_sel_d = next_ch;
            state_d   = S_SETTLE;
          end else begin
            eoc_d = 1'b1;
            if (cont && first_found) begin
              mask_d    = ch_mask;
              mux_sel_d = first_ch;
              state_d   = S_SETTLE;
            end else begin
              busy_d  = 1'b0;
              state_d = S_IDLE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      mask_q       <= '0;
      mux_sel_q    <= '0;
      settle_q     <= '0;
      bit_q        <= '0;
      acc_q        <= '0;
      busy_q       <= 1'b0;
      eoc_q        <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_q       <= '0;
      dout_ch_q    <= '0;
`ifdef SAR_AVG_EN
      sum_q        <= '0;
      avg_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      mux_sel_q    <= mux_sel_d;
      settle_q     <= settle_d;
      bit_q        <= bit_d;
      acc_q        <= acc_d;
      busy_q       <= busy_d;
      eoc_q        <= eoc_d;
      dout_valid_q <= dout_valid_d;
      dout_q       <= dout_d;
      dout_ch_q    <= dout_ch_d;
`ifdef SAR_AVG_EN
      sum_q        <= sum_d;
      avg_q        <= avg_d;
`endif
    end
  end

  assign mux_sel    = mux_sel_q;
  assign sample     = (state_q == S_SETTLE);
  assign DACF       = (state_q == S_CONV) ? trial : '0;
  assign busy       = busy_q;
  assign eoc        = eoc_q;
  assign dout_valid = dout_valid_q;
  assign dout       = dout_q;
  assign dout_ch    = dout_ch_q;

endmodule

// File: tb/tb_sar_adc_scan.sv
// tb/tb_sar_adc_scan.sv - self-checking bench for sar_adc_scan
module tb_sar_adc_scan;

`ifdef SAR_AVG_EN
  localparam int LAT = 2 + 8 * 4 + 1;
`else
  localparam int LAT = 2 + 8 + 1;
`endif

  logic       clk = 1'b0;
  logic       rst, start, cont, cmp, dout_ready;
  logic [3:0] ch_mask;
  logic [1:0] mux_sel, dout_ch;
  logic       sample, busy, eoc, dout_valid;
  logic [7:0] DACF, dout;
  logic [7:0] vin [4];

  sar_adc_scan dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .ch_mask(ch_mask),
    .cmp(cmp), .mux_sel(mux_sel), .sample(sample), .DACF(DACF), .busy(busy),
    .eoc(eoc), .dout_valid(dout_valid), .dout_ready(dout_ready), .dout(dout),
    .dout_ch(dout_ch)
  );

  // Ideal comparator against the selected analog input.
  assign cmp = (DACF <= vin[mux_sel]);

  always #5 clk = ~clk;

  typedef struct {int ch; int val;} exp_t;
  typedef struct {int ch; logic [7:0] vin; logic [7:0] exp_dout; logic [1:0] exp_ch;} vec_t;

  exp_t q[$];
  int   checks = 0, errors = 0, cyc = 0, eoc_cnt = 0, hs_cnt = 0, free_ch = -1;
  logic held = 1'b0;
  logic [9:0] held_val;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard: expected results are simply the channel inputs, in ascending channel order.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held && dout_valid) chk("stable_while_stalled", {dout_ch, dout}, held_val);
      if (eoc) eoc_cnt++;
      if (dout_valid && dout_ready) begin
        hs_cnt++;
        if (free_ch >= 0) begin
          e.ch = free_ch; e.val = int'(vin[free_ch]);
          chk("dout_ch", dout_ch, e.ch);
          chk("dout", dout, e.val);
        end else if (q.size() == 0) begin
          chk("unexpected_result", {dout_ch, dout}, 10'h3ff);
        end else begin
          e = q.pop_front();
          chk("dout_ch", dout_ch, e.ch);
          chk("dout", dout, e.val);
        end
      end
      held = dout_valid && !dout_ready;
      held_val = {dout_ch, dout};
    end
  end

  task automatic push_scan(input logic [3:0] m);
    exp_t e;
    for (int c = 0; c < 4; c++) if (m[c]) begin
      e.ch = c; e.val = int'(vin[c]);
      q.push_back(e);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while ((busy || dout_valid || q.size() != 0) && n < max) begin
      tick();
      n++;
    end
    chk("idle_within_bound", n < max, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mux_sel"}, mux_sel, 0);
    chk({tag, "_sample"}, sample, 0);
    chk({tag, "_dacf"}, DACF, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_eoc"}, eoc, 0);
    chk({tag, "_valid"}, dout_valid, 0);
    chk({tag, "_dout"}, {dout_ch, dout}, 0);
  endtask

  vec_t tbl[8];

  initial begin
    int n, k, e0, h0;
    int t[4];
    logic [3:0] m;
    tbl[0] = '{0, 8'd153, 8'd153, 2'd0};
    tbl[1] = '{1, 8'h40,  8'h40,  2'd1};
    tbl[2] = '{3, 8'hFF,  8'hFF,  2'd3};
    tbl[3] = '{2, 8'h00,  8'h00,  2'd2};
    tbl[4] = '{2, 8'hFF,  8'hFF,  2'd2};
    tbl[5] = '{1, 8'h01,  8'h01,  2'd1};
    tbl[6] = '{3, 8'h80,  8'h80,  2'd3};
    tbl[7] = '{0, 8'h7F,  8'h7F,  2'd0};

    rst = 1'b1; start = 1'b0; cont = 1'b0; dout_ready = 1'b1; ch_mask = '0;
    for (int i = 0; i < 4; i++) vin[i] = '0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Single-channel conversions: value, tag, latency and eoc.
    for (int i = 0; i < 8; i++) begin
      vin[tbl[i].ch] = tbl[i].vin;
      ch_mask = 4'(1 << tbl[i].ch);
      push_scan(ch_mask);
      pulse_start();
      chk("busy_after_start", busy, 1);
      n = 0;
      while (!dout_valid && n < 100) begin
        tick();
        n++;
      end
      chk("latency", n, LAT);
      chk("vec_dout", dout, tbl[i].exp_dout);
      chk("vec_ch", dout_ch, tbl[i].exp_ch);
      chk("vec_eoc", eoc, 1);
      chk("vec_busy_low", busy, 0);
      tick();
      chk("vec_eoc_pulse", eoc, 0);
      wait_idle(200);
    end

    // Start with an empty mask does nothing.
    ch_mask = 4'b0000;
    pulse_start();
    k = 0;
    repeat (20) begin
      if (busy || eoc) k++;
      tick();
    end
    chk("empty_mask_ignored", k, 0);

    // Two channels; restart attempt and mask change mid-scan must be ignored.
    vin[1] = 8'h40; vin[3] = 8'hFF; vin[0] = 8'h11;
    ch_mask = 4'b1010;
    push_scan(ch_mask);
    e0 = eoc_cnt;
    pulse_start();
    repeat (3) tick();
    ch_mask = 4'b0001;
    pulse_start();
    n = 0;
    while (!(dout_valid && dout_ch == 2'd3) && n < 200) begin
      if (dout_valid) chk("eoc_not_with_ch1", eoc, 0);
      tick();
      n++;
    end
    chk("ch3_eoc", eoc, 1);
    chk("ch3_busy_fell", busy, 0);
    wait_idle(200);
    chk("scan_eoc_count", eoc_cnt - e0, 1);

    // Back-pressure: result held, sequencer stalls, nothing lost.
    vin[0] = 8'h5A; vin[1] = 8'hA5;
    ch_mask = 4'b0011;
    push_scan(ch_mask);
    dout_ready = 1'b0;
    pulse_start();
    repeat (30) tick();
    chk("stall_valid", dout_valid, 1);
    chk("stall_held_ch0", {dout_ch, dout}, {2'd0, 8'h5A});
    chk("stall_busy", busy, 1);
    chk("stall_in_load", {sample, DACF}, 9'd0);
    dout_ready = 1'b1;
    wait_idle(200);

    // Continuous scanning: back-to-back scans, then stop after the current one.
    free_ch = 2; vin[2] = 8'd77; ch_mask = 4'b0100; cont = 1'b1;
    e0 = eoc_cnt; h0 = hs_cnt; k = 0; n = 0;
    pulse_start();
    while (k < 3 && n < 500) begin
      if (eoc) begin
        t[k] = cyc;
        chk("cont_busy_kept", busy, 1);
        k++;
      end
      if (k < 3) tick();
      n++;
    end
    chk("cont_three_scans", k, 3);
    cont = 1'b0;
    chk("cont_period_1", t[1] - t[0], LAT);
    chk("cont_period_2", t[2] - t[1], LAT);
    wait_idle(200);
    repeat (20) tick();
    chk("cont_eoc_total", eoc_cnt - e0, 4);
    chk("cont_results_total", hs_cnt - h0, 4);
    free_ch = -1;

    // Reset in the 4th conversion cycle drops everything, including a pending result.
    vin[0] = 8'd10; vin[1] = 8'd200; ch_mask = 4'b0011;
    dout_ready = 1'b0;
    pulse_start();
    n = 0;
    while (!(mux_sel == 2'd1 && DACF == 8'h80) && n < 200) begin
      tick();
      n++;
    end
    chk("reach_conv_ch1", n < 200, 1);
    repeat (3) tick();
    chk("pending_before_rst", dout_valid, 1);
    chk("in_conv_before_rst", DACF != 8'h00, 1);
    rst = 1'b1;
    tick();
    check_reset_outputs("midrst");
    rst = 1'b0; dout_ready = 1'b1;
    tick();
    vin[0] = 8'd153; ch_mask = 4'b0001;
    push_scan(ch_mask);
    pulse_start();
    wait_idle(200);

    // Random scans with random back-pressure and ignored mid-scan disturbances.
    for (int s = 0; s < 15; s++) begin
      for (int c = 0; c < 4; c++) vin[c] = 8'($urandom_range(0, 255));
      m = 4'($urandom_range(1, 15));
      ch_mask = m;
      push_scan(m);
      pulse_start();
      n = 0;
      while ((busy || dout_valid || q.size() != 0) && n < 3000) begin
        dout_ready = ($urandom_range(0, 3) != 0);
        ch_mask = 4'($urandom_range(0, 15));
        if (busy && $urandom_range(0, 7) == 0) start = 1'b1;
        tick();
        start = 1'b0;
        n++;
      end
      chk("random_scan_done", n < 3000, 1);
      dout_ready = 1'b1;
    end

`ifdef SAR_AVG_EN
    // Averaging: input alternates 100/103 between conversions.
    begin
      logic pend;
      pend = 1'b0;
      vin[2] = 8'd100; ch_mask = 4'b0100; free_ch = -1;
      q.push_back('{2, 101});
      pulse_start();
      n = 0;
      while ((busy || dout_valid || q.size() != 0) && n < 300) begin
        tick();
        if (pend) vin[2] = (vin[2] == 8'd100) ? 8'd103 : 8'd100;
        pend = DACF[0];
        n++;
      end
      chk("avg_done", n < 300, 1);
    end
`endif

    chk("scoreboard_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
